// File: rtl/qbus_dma_master.sv
`default_nettype none
// ============================================================================
// Module   : qbus_dma_master
// Purpose  : Qbus DMA bus-master sequencer. Takes 1..8 word DATI/DATO
//            commands, arbitrates via BDMR/BDMGI/BSACK, runs the bus cycles
//            on BDAL and releases the bus after each command.
// Revision : 1.0  initial release
// ============================================================================
module qbus_dma_master #(
    parameter int T_ASU = 15,
    parameter int T_AH  = 10,
    parameter int T_DSU = 10,
    parameter int T_RDK = 20,
    parameter int T_TO  = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [21:0] cmd_addr,
    input  logic [2:0]  cmd_len,
    input  logic [15:0] wr_data,
    output logic        wr_req,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic [21:0] BDALf_IN,
    input  logic        BRPLYf,
    input  logic        BDMGIf,
    input  logic        BSYNCf,
    output logic [21:0] BDALf_OUT,
    output logic [21:0] BDALf_OE,
    output logic        Outbound,
    output logic        BSYNCg,
    output logic        BDINg,
    output logic        BDOUTg,
    output logic        BWTBTg,
    output logic        BBS7g,
    output logic        BDMRg,
    output logic        BSACKg,
    output logic        BDMGOg
);

    localparam int C_CW = 16;

    localparam logic [C_CW-1:0] c_ASU_LAST = C_CW'(T_ASU - 1);
    localparam logic [C_CW-1:0] c_AH_LAST  = C_CW'(T_AH - 1);
    localparam logic [C_CW-1:0] c_DSU_END  = C_CW'(T_DSU);
    localparam logic [C_CW-1:0] c_RDK_LAST = C_CW'(T_RDK - 1);
    localparam logic [C_CW-1:0] c_TO_LAST  = C_CW'(T_TO - 1);

    localparam logic [3:0] c_IDLE      = 4'd0;
    localparam logic [3:0] c_REQ       = 4'd1;
    localparam logic [3:0] c_GRANT     = 4'd2;
    localparam logic [3:0] c_ADDR      = 4'd3;
    localparam logic [3:0] c_SYNC      = 4'd4;
    localparam logic [3:0] c_DATA      = 4'd5;
    localparam logic [3:0] c_WAIT_RPLY = 4'd6;
    localparam logic [3:0] c_END       = 4'd7;
    localparam logic [3:0] c_RELEASE   = 4'd8;
    localparam logic [3:0] c_ABORT     = 4'd9;

    logic [3:0]      r_state;
    logic [C_CW-1:0] r_cnt;
    logic [21:0]     r_addr;
    logic            r_write;
    logic [2:0]      r_left;
    logic            r_bbs7;
    logic [15:0]     r_wdata;
    logic            r_got_rply;
    logic [15:0]     r_rd_data;
    logic            r_rd_valid;

    logic r_rply_meta, r_rply;
    logic r_dmg_meta,  r_dmg;
    logic r_sync_meta, r_sync;

    logic [21:0] w_next_addr;
    logic        w_unused;

    assign w_next_addr = r_addr + 22'd2;
    // Byte-address bit 0 and the upper BDAL inputs carry nothing for word DATI.
    assign w_unused    = ^{cmd_addr[0], BDALf_IN[21:16]};

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

    // Two-flop synchronizers; stored active-high (bus lines are active-low).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rply_meta <= 1'b0;
            r_rply      <= 1'b0;
            r_dmg_meta  <= 1'b0;
            r_dmg       <= 1'b0;
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_rply_meta <= ~BRPLYf;
            r_rply      <= r_rply_meta;
            r_dmg_meta  <= ~BDMGIf;
            r_dmg       <= r_dmg_meta;
            r_sync_meta <= ~BSYNCf;
            r_sync      <= r_sync_meta;
        end
    end

    // Bus-master sequencer: one pass ADDR..END per word, bus released per command.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_left     <= '0;
            r_bbs7     <= 1'b0;
            r_wdata    <= '0;
            r_got_rply <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_addr  <= {cmd_addr[21:1], 1'b0};
                        r_write <= cmd_write;
                        r_left  <= cmd_len;
                        r_bbs7  <= &cmd_addr[21:13];
                        r_state <= c_REQ;
                    end
                end
                c_REQ: begin
                    if (r_dmg) r_state <= c_GRANT;
                end
                c_GRANT: begin
                    // Previous master must have finished its cycle.
                    if (!r_sync && !r_rply) begin
                        r_cnt   <= '0;
                        r_state <= c_ADDR;
                    end
                end
                c_ADDR: begin
                    if (r_cnt == c_ASU_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_SYNC;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_SYNC: begin
                    if (r_cnt == c_AH_LAST) begin
                        r_cnt      <= '0;
                        r_got_rply <= 1'b0;
                        // DATI asserts BDIN right away, so it skips the data-setup phase.
                        r_state    <= r_write ? c_DATA : c_WAIT_RPLY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DATA: begin
                    if (r_cnt == '0) r_wdata <= wr_data;
                    if (r_cnt == c_DSU_END) begin
                        r_cnt   <= '0;
                        r_state <= c_WAIT_RPLY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_WAIT_RPLY: begin
                    if (!r_got_rply) begin
                        if (r_rply) begin
                            r_got_rply <= 1'b1;
                            r_cnt      <= '0;
                        end else if (r_cnt == c_TO_LAST) begin
                            r_state <= c_ABORT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (r_cnt == c_RDK_LAST) begin
                        if (!r_write) begin
                            r_rd_data  <= ~BDALf_IN[15:0];
                            r_rd_valid <= 1'b1;
                        end
                        r_state <= c_END;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_END: begin
                    if (!r_rply) begin
                        r_cnt <= '0;
                        if (r_left != 3'd0) begin
                            r_left  <= r_left - 1'b1;
                            r_addr  <= w_next_addr;
                            r_bbs7  <= &w_next_addr[21:13];
                            r_state <= c_ADDR;
                        end else begin
                            r_state <= c_RELEASE;
                        end
                    end
                end
                c_RELEASE: r_state <= c_IDLE;
                c_ABORT:   r_state <= c_IDLE;
                default:   r_state <= c_IDLE;
            endcase
        end
    end

    // Output decode from state, so an asynchronous reset drops every drive at once.
    always_comb begin
        cmd_ready = (r_state == c_IDLE);
        busy      = (r_state != c_IDLE);
        BDMRg     = (r_state == c_REQ);
        BSACKg    = 1'b0;
        BSYNCg    = 1'b0;
        BDINg     = 1'b0;
        BDOUTg    = 1'b0;
        BWTBTg    = 1'b0;
        BBS7g     = 1'b0;
        Outbound  = 1'b0;
        BDALf_OUT = '0;
        BDALf_OE  = '0;
        wr_req    = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (r_state)
            c_GRANT: BSACKg = 1'b1;
            c_ADDR, c_SYNC: begin
                BSACKg    = 1'b1;
                BSYNCg    = (r_state == c_SYNC);
                BDALf_OUT = r_addr;
                BDALf_OE  = '1;
                Outbound  = 1'b1;
                BBS7g     = r_bbs7;
                BWTBTg    = r_write;
            end
            c_DATA: begin
                // Only DATO reaches here; address lingers one cycle while the word is fetched.
                BSACKg    = 1'b1;
                BSYNCg    = 1'b1;
                BDALf_OE  = '1;
                Outbound  = 1'b1;
                BDALf_OUT = (r_cnt == '0) ? r_addr : {6'd0, r_wdata};
                wr_req    = (r_cnt == '0);
            end
            c_WAIT_RPLY, c_END: begin
                BSACKg = 1'b1;
                BSYNCg = 1'b1;
                BDINg  = (r_state == c_WAIT_RPLY) && !r_write;
                BDOUTg = (r_state == c_WAIT_RPLY) && r_write;
                if (r_write) begin
                    BDALf_OUT = {6'd0, r_wdata};
                    BDALf_OE  = '1;
                    Outbound  = 1'b1;
                end
            end
            c_RELEASE: done  = 1'b1;
            c_ABORT:   error = 1'b1;
            default: ;
        endcase
    end

    // Grant daisy-chain pass-through on the raw input.
    assign BDMGOg = !BDMGIf && !(BDMRg || BSACKg);

endmodule
`default_nettype wire

// File: tb/tb_qbus_dma_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_qbus_dma_master
// Purpose  : Directed self-checking bench for qbus_dma_master with a simple
//            Qbus arbiter/slave driven from tasks.
// Revision : 1.0  initial release
// ============================================================================
module tb_qbus_dma_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [21:0] cmd_addr;
    logic [2:0]  cmd_len;
    logic [15:0] wr_data;
    logic        wr_req;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy, done, error;
    logic [21:0] BDALf_IN;
    logic        BRPLYf, BDMGIf, BSYNCf;
    logic [21:0] BDALf_OUT, BDALf_OE;
    logic        Outbound, BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMRg, BSACKg, BDMGOg;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    qbus_dma_master dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_req(wr_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done), .error(error),
        .BDALf_IN(BDALf_IN), .BRPLYf(BRPLYf), .BDMGIf(BDMGIf), .BSYNCf(BSYNCf),
        .BDALf_OUT(BDALf_OUT), .BDALf_OE(BDALf_OE), .Outbound(Outbound),
        .BSYNCg(BSYNCg), .BDINg(BDINg), .BDOUTg(BDOUTg), .BWTBTg(BWTBTg),
        .BBS7g(BBS7g), .BDMRg(BDMRg), .BSACKg(BSACKg), .BDMGOg(BDMGOg)
    );

    // ---------------- bus monitor (sampled on the falling edge) ----------------
    logic        prev_bdmr = 1'b0, prev_bsync = 1'b0, prev_bdout = 1'b0, prev_bdin = 1'b0;
    logic [21:0] prev_out = '0;
    logic [21:0] m_exp_wdata = '0;
    logic [21:0] m_addr [0:7];
    logic        m_bbs7_at [0:7];
    logic [15:0] m_rd [0:7];
    logic [21:0] m_dout_val = '0;
    int m_handoff, m_leak, m_nwr, m_ndone, m_nerr, m_nrd, m_na;
    int m_asu_min, m_run_a, m_ah, m_bbs7_sync, m_run_d, m_dsu, m_same_rise;

    task automatic clear_mon();
        m_handoff = 0; m_leak = 0; m_nwr = 0; m_ndone = 0; m_nerr = 0; m_nrd = 0;
        m_na = 0; m_asu_min = 1000000; m_run_a = 0; m_ah = 0; m_bbs7_sync = 0;
        m_run_d = 0; m_dsu = 0; m_same_rise = 0; m_dout_val = '0;
    endtask

    always @(negedge clock) begin
        if (prev_bdmr && BSACKg && !BDMRg) m_handoff++;
        if (BDMRg && BDMGOg) m_leak++;
        if (wr_req) m_nwr++;
        if (done) m_ndone++;
        if (error) m_nerr++;
        if (rd_valid) begin
            if (m_nrd < 8) m_rd[m_nrd] = rd_data;
            m_nrd++;
        end
        if (BSYNCg && !prev_bsync && ((BDINg && !prev_bdin) || (BDOUTg && !prev_bdout)))
            m_same_rise++;
        if (BSYNCg && !prev_bsync) begin
            if (m_na < 8) begin
                m_addr[m_na]    = BDALf_OUT;
                m_bbs7_at[m_na] = BBS7g;
            end
            m_na++;
            if (m_run_a < m_asu_min) m_asu_min = m_run_a;
            m_ah = 0;
            m_bbs7_sync = 0;
        end
        if (!BSYNCg && BDALf_OE == 22'h3FFFFF && Outbound)
            m_run_a = (m_run_a != 0 && BDALf_OUT == prev_out) ? m_run_a + 1 : 1;
        else
            m_run_a = 0;
        if (BSYNCg && BDALf_OE == 22'h3FFFFF && m_na > 0 && m_na <= 8 && BDALf_OUT == m_addr[m_na-1])
            m_ah++;
        if (BSYNCg && BBS7g) m_bbs7_sync++;
        if (BDOUTg && !prev_bdout) begin
            m_dsu      = m_run_d;
            m_dout_val = BDALf_OUT;
        end
        if (!BDOUTg && BDALf_OE == 22'h3FFFFF && BDALf_OUT == m_exp_wdata) m_run_d++;
        else m_run_d = 0;
        prev_bdmr  = BDMRg;
        prev_bsync = BSYNCg;
        prev_bdout = BDOUTg;
        prev_bdin  = BDINg;
        prev_out   = BDALf_OUT;
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic w, input logic [21:0] a, input logic [2:0] l);
        @(negedge clock);
        cmd_write = w; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        n_vec++;
        if ({BDMRg, busy, cmd_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL accept_to_bdmr: got bdmr/busy/ready=%b want 110", {BDMRg, busy, cmd_ready});
        end
    endtask

    task automatic do_grant(input int dly);
        int n;
        repeat (dly) @(negedge clock);
        BDMGIf = 1'b0;
        #1;
        n_vec++;
        if (BDMGOg !== 1'b0) begin
            n_fail++;
            $display("FAIL grant_hold_in_req: got BDMGOg=%b want 0", BDMGOg);
        end
        n = 0;
        while (!BSACKg && n < 100) begin @(negedge clock); n++; end
        BDMGIf = 1'b1;
        n_vec++;
        if (n >= 100) begin
            n_fail++;
            $display("FAIL grant_taken: got no BSACK in %0d cycles want BSACK", n);
        end
    endtask

    task automatic slave_word(input int dly, input logic [15:0] d, output bit ok);
        int n;
        ok = 1'b1;
        n = 0;
        while (!(BDINg || BDOUTg) && n < 3000) begin @(negedge clock); n++; end
        if (n >= 3000) begin ok = 1'b0; return; end
        repeat (dly) @(negedge clock);
        BDALf_IN = ~{6'd0, d};
        BRPLYf   = 1'b0;
        n = 0;
        while ((BDINg || BDOUTg) && n < 3000) begin @(negedge clock); n++; end
        if (n >= 3000) ok = 1'b0;
        BRPLYf   = 1'b1;
        BDALf_IN = 22'h3FFFFF;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || error) && n < 3000) begin @(negedge clock); n++; end
        n_vec++;
        if (n >= 3000) begin
            n_fail++;
            $display("FAIL command_end: got no done/error in %0d cycles want one", n);
        end
        repeat (3) @(negedge clock);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_vec++;
        if ({cmd_ready, busy, done, error, rd_valid, wr_req, BSYNCg, BDINg, BDOUTg,
             BWTBTg, BBS7g, BDMRg, BSACKg, Outbound} !== 14'b10000000000000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 10000000000000",
                     {cmd_ready, busy, done, error, rd_valid, wr_req, BSYNCg, BDINg, BDOUTg,
                      BWTBTg, BBS7g, BDMRg, BSACKg, Outbound});
        end
        n_vec++;
        if ({BDALf_OE, BDALf_OUT, rd_data} !== 60'd0) begin
            n_fail++;
            $display("FAIL reset_bus: got oe=%h out=%h rd=%h want 0", BDALf_OE, BDALf_OUT, rd_data);
        end
    endtask

    task automatic test_grant_passthrough();
        @(negedge clock);
        BDMGIf = 1'b0;
        #1;
        n_vec++;
        if (BDMGOg !== 1'b1) begin
            n_fail++;
            $display("FAIL grant_pass_idle: got %b want 1", BDMGOg);
        end
        BDMGIf = 1'b1;
        #1;
        n_vec++;
        if (BDMGOg !== 1'b0) begin
            n_fail++;
            $display("FAIL grant_pass_negate: got %b want 0", BDMGOg);
        end
        // Leave the grant low long enough to pass the synchronizer; nothing must happen.
        BDMGIf = 1'b0;
        repeat (4) @(negedge clock);
        BDMGIf = 1'b1;
        repeat (4) @(negedge clock);
        n_vec++;
        if ({busy, BSACKg} !== 2'b00) begin
            n_fail++;
            $display("FAIL grant_idle_ignored: got busy/bsack=%b want 00", {busy, BSACKg});
        end
    endtask

    task automatic test_dato();
        bit ok;
        clear_mon();
        m_exp_wdata = 22'h00A5C3;
        wr_data     = 16'hA5C3;
        issue(1'b1, 22'h001000, 3'd0);
        do_grant(5);
        slave_word(30, 16'h0000, ok);
        n_vec++;
        if (!ok) begin n_fail++; $display("FAIL dato_handshake: got timeout want reply"); end
        wait_end();
        n_vec++;
        if (m_handoff !== 1 || m_leak !== 0) begin
            n_fail++;
            $display("FAIL dato_handoff: got handoff=%0d leak=%0d want 1/0", m_handoff, m_leak);
        end
        n_vec++;
        if (m_na !== 1 || m_addr[0] !== 22'h001000) begin
            n_fail++;
            $display("FAIL dato_addr: got n=%0d addr=%h want 1/001000", m_na, m_addr[0]);
        end
        n_vec++;
        if (m_asu_min < 15 || m_ah < 10) begin
            n_fail++;
            $display("FAIL dato_addr_timing: got asu=%0d ah=%0d want >=15/>=10", m_asu_min, m_ah);
        end
        n_vec++;
        if (m_dsu !== 10 || m_dout_val !== 22'h00A5C3) begin
            n_fail++;
            $display("FAIL dato_data_setup: got dsu=%0d data=%h want 10/00a5c3", m_dsu, m_dout_val);
        end
        n_vec++;
        if (m_nwr !== 1 || m_ndone !== 1 || m_nerr !== 0) begin
            n_fail++;
            $display("FAIL dato_pulses: got wr_req=%0d done=%0d err=%0d want 1/1/0", m_nwr, m_ndone, m_nerr);
        end
        n_vec++;
        if ({BSACKg, busy, cmd_ready, BDALf_OE != 22'd0} !== 4'b0010) begin
            n_fail++;
            $display("FAIL dato_release: got bsack/busy/ready/oe=%b want 0010",
                     {BSACKg, busy, cmd_ready, BDALf_OE != 22'd0});
        end
    endtask

    task automatic test_dati_wrap();
        bit ok;
        clear_mon();
        m_exp_wdata = 22'h3FFFFF;
        issue(1'b0, 22'h3FFFFC, 3'd2);
        do_grant(2);
        for (int i = 0; i < 3; i++) begin
            slave_word(8, 16'(16'h1111 * (i + 1)), ok);
            n_vec++;
            if (!ok) begin n_fail++; $display("FAIL dati_handshake: got timeout on word %0d want reply", i); end
        end
        wait_end();
        n_vec++;
        if (m_na !== 3 || m_addr[0] !== 22'h3FFFFC || m_addr[1] !== 22'h3FFFFE || m_addr[2] !== 22'h000000) begin
            n_fail++;
            $display("FAIL dati_addrs: got n=%0d %h %h %h want 3 3ffffc 3ffffe 000000",
                     m_na, m_addr[0], m_addr[1], m_addr[2]);
        end
        n_vec++;
        if ({m_bbs7_at[0], m_bbs7_at[1], m_bbs7_at[2]} !== 3'b110) begin
            n_fail++;
            $display("FAIL dati_bbs7: got %b want 110", {m_bbs7_at[0], m_bbs7_at[1], m_bbs7_at[2]});
        end
        n_vec++;
        if (m_nrd !== 3 || m_rd[0] !== 16'h1111 || m_rd[1] !== 16'h2222 || m_rd[2] !== 16'h3333) begin
            n_fail++;
            $display("FAIL dati_rdata: got n=%0d %h %h %h want 3 1111 2222 3333", m_nrd, m_rd[0], m_rd[1], m_rd[2]);
        end
        n_vec++;
        if (m_ah !== 10 || m_asu_min < 15) begin
            n_fail++;
            $display("FAIL dati_addr_timing: got ah=%0d asu=%0d want 10/>=15", m_ah, m_asu_min);
        end
        n_vec++;
        if (m_ndone !== 1 || m_nwr !== 0 || m_same_rise !== 0) begin
            n_fail++;
            $display("FAIL dati_pulses: got done=%0d wr_req=%0d same_rise=%0d want 1/0/0", m_ndone, m_nwr, m_same_rise);
        end
    endtask

    task automatic test_io_page();
        bit ok;
        clear_mon();
        m_exp_wdata = 22'h000F0F;
        wr_data     = 16'h0F0F;
        issue(1'b1, 22'h3FF400, 3'd0);
        do_grant(1);
        slave_word(3, 16'h0000, ok);
        n_vec++;
        if (!ok) begin n_fail++; $display("FAIL io_handshake: got timeout want reply"); end
        wait_end();
        n_vec++;
        if (m_na !== 1 || m_addr[0] !== 22'h3FF400 || m_bbs7_at[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL io_bbs7_addr: got n=%0d addr=%h bbs7=%b want 1/3ff400/1", m_na, m_addr[0], m_bbs7_at[0]);
        end
        n_vec++;
        if (m_bbs7_sync !== 10 || m_dout_val !== 22'h000F0F || m_ndone !== 1) begin
            n_fail++;
            $display("FAIL io_bbs7_hold: got bbs7cyc=%0d data=%h done=%0d want 10/000f0f/1",
                     m_bbs7_sync, m_dout_val, m_ndone);
        end
    endtask

    task automatic test_timeout();
        int n;
        clear_mon();
        m_exp_wdata = 22'h3FFFFF;
        issue(1'b0, 22'h000100, 3'd3);
        do_grant(1);
        n = 0;
        while (!BDINg && n < 200) begin @(negedge clock); n++; end
        n_vec++;
        if (n >= 200) begin n_fail++; $display("FAIL to_bdin: got no BDIN want BDIN"); end
        n = 0;
        while (!error && n < 1100) begin @(negedge clock); n++; end
        n_vec++;
        if (n !== 1000) begin
            n_fail++;
            $display("FAIL to_latency: got %0d cycles want 1000", n);
        end
        n_vec++;
        if ({BSYNCg, BDINg, BSACKg, Outbound, BDALf_OE != 22'd0} !== 5'b00000) begin
            n_fail++;
            $display("FAIL to_release: got sync/din/sack/outb/oe=%b want 00000",
                     {BSYNCg, BDINg, BSACKg, Outbound, BDALf_OE != 22'd0});
        end
        repeat (5) @(negedge clock);
        n_vec++;
        if (m_nerr !== 1 || m_ndone !== 0 || m_nrd !== 0 || m_na !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL to_pulses: got err=%0d done=%0d rd=%0d words=%0d busy=%b want 1/0/0/1/0",
                     m_nerr, m_ndone, m_nrd, m_na, busy);
        end
    endtask

    task automatic test_reset_midop();
        int n;
        clear_mon();
        m_exp_wdata = 22'h001234;
        wr_data     = 16'h1234;
        issue(1'b1, 22'h000200, 3'd1);
        do_grant(1);
        n = 0;
        while (!BDOUTg && n < 200) begin @(negedge clock); n++; end
        n_vec++;
        if (n >= 200) begin n_fail++; $display("FAIL rst_bdout: got no BDOUT want BDOUT"); end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if ({BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMRg, BSACKg, Outbound} !== 8'd0 ||
            BDALf_OE !== 22'd0) begin
            n_fail++;
            $display("FAIL rst_async: got drives=%b oe=%h want 0/0",
                     {BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMRg, BSACKg, Outbound}, BDALf_OE);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_vec++;
        if ({cmd_ready, busy} !== 2'b10 || m_ndone !== 0 || m_nerr !== 0) begin
            n_fail++;
            $display("FAIL rst_idle: got ready/busy=%b done=%0d err=%0d want 10/0/0",
                     {cmd_ready, busy}, m_ndone, m_nerr);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_data   = '0;
        BDALf_IN  = 22'h3FFFFF;
        BRPLYf    = 1'b1;
        BDMGIf    = 1'b1;
        BSYNCf    = 1'b1;
        clear_mon();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        test_reset();
        test_grant_passthrough();
        test_dato();
        test_dati_wrap();
        test_io_page();
        test_timeout();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qbus_dma_master.md
# qbus_dma_master

Qbus DMA bus-master sequencer for the MSCP controller board. It accepts word-transfer commands from the H723-facing logic, arbitrates for the Qbus via BDMR/BDMGI/BSACK, and runs DATI or DATO cycles on BDAL. It releases the bus after each command. It shares the BDAL pad drivers and gate drivers with the slave register logic, and drives them only while it owns the bus.

## Interface
Parameters (cycle counts at 100 MHz nominal):
- T_ASU, 15, address setup on BDAL before BSYNC asserted (150 ns)
- T_AH, 10, address hold after BSYNC asserted (100 ns)
- T_DSU, 10, DATO data setup before BDOUT asserted (100 ns)
- T_RDK, 20, DATI deskew from synchronized BRPLY to data latch (200 ns)
- T_TO, 1000, BRPLY timeout (10 µs)

Ports:
- clock  in  1  system clock; everything is clocked on posedge except the grant pass-through
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE; a command is accepted when valid && ready
- cmd_write  in  1  1 = DATO, 0 = DATI
- cmd_addr  in  22  Qbus byte address; bit 0 is forced to 0
- cmd_len  in  3  word count minus 1 (1..8 words)
- wr_data  in  16  DATO word, sampled in the cycle wr_req is high (show-ahead source)
- wr_req  out  1  one-cycle pulse that consumes one wr_data word
- rd_data  out  16  DATI word, valid while rd_valid is high
- rd_valid  out  1  one-cycle pulse per word read
- busy  out  1  high whenever the block is not in IDLE
- done  out  1  one-cycle pulse when a command completes normally
- error  out  1  one-cycle pulse on BRPLY timeout
- BDALf_IN  in  22  bus lines, low = asserted (data is inverted on input)
- BRPLYf, BDMGIf, BSYNCf  in  1  bus lines, low = asserted
- BDALf_OUT  out  22  true data; high drives the line asserted
- BDALf_OE  out  22  FPGA pad enables
- Outbound  out  1  BDAL gate-driver enable
- BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMRg, BSACKg, BDMGOg  out  1  gate drives, high = asserted

## Operation
- BRPLYf, BDMGIf and BSYNCf each pass through a 2-flop synchronizer before use in the FSM.
- Reset value of every output is 0, except BDMGOg, which follows the pass-through equation below.
- Reset is asynchronous. Asserting it mid-operation negates all strobes and releases BDAL immediately. The command in progress is discarded with no done or error pulse.
- Grant pass-through: BDMGOg = !BDMGIf && !(BDMRg || BSACKg). This path is combinational on the raw input.
- FSM states and transitions:
  - IDLE: on accept, latch the command. Set BBS7 = (addr[21:13] == all ones). Go to REQ.
  - REQ: assert BDMRg and wait for synchronized BDMGI.
  - GRANT: assert BSACKg and negate BDMRg in the same cycle. Wait until synchronized BSYNC and BRPLY are both negated.
  - ADDR: drive the address with OE=all ones and Outbound=1. BBS7g follows the latched BBS7 flag. BWTBTg = write. Hold for T_ASU cycles.
  - SYNC: assert BSYNCg and hold the address for T_AH cycles. Then negate BBS7g and BWTBTg and release BDAL for DATI.
  - DATA:
    - DATO: pulse wr_req in the first cycle, drive wr_data, wait T_DSU cycles, then assert BDOUTg.
    - DATI: assert BDINg in the first cycle.
  - WAIT_RPLY: on synchronized BRPLY, wait T_RDK cycles, then go to END.
    - DATI: latch ~BDALf_IN[15:0] into rd_data and pulse rd_valid.
    - If T_TO cycles pass without BRPLY, go to ABORT.
  - END: negate BDIN/BDOUT and wait for synchronized BRPLY to negate. For DATO, keep driving data until this point. Then negate BSYNCg and release BDAL.
    - Words remaining: address += 2 (mod 2^22), recompute BBS7, go to ADDR.
    - Otherwise go to RELEASE.
  - RELEASE: negate BSACKg, pulse done, go to IDLE.
  - ABORT: negate all strobes, BSYNC and BDAL. Negate BSACKg, pulse error, go to IDLE. Remaining words are abandoned and no further wr_req pulses are issued.
- The address can wrap within a command from 0x3FFFFE to 0x000000; no special handling.

## Timing
- Accept to BDMRg asserted: 1 cycle.
- Synchronized-grant latency: 2–3 cycles after BDMGIf falls.
- BSACKg asserts on the same edge that BDMRg negates.
- Address on BDAL at least T_ASU cycles before BSYNCg, and held T_AH cycles after it.
- DATO data on BDAL T_DSU cycles before BDOUTg, and held until synchronized BRPLY negates.
- BSYNCg and BDIN/BDOUT never rise in the same cycle.
- The timeout counter starts when BDIN/BDOUT asserts and clears per word.

## Test plan
- DATO, addr 0x001000, len 0, wr_data 0xA5C3, grant after 5 cycles, slave replies 30 cycles after BDOUT:
  - Required: BDMR→BSACK handoff seen.
  - Address 0x001000 held ≥15 cycles before BSYNC.
  - BDOUT asserts 10 cycles after data is driven; BDALf_OUT = 0xA5C3.
  - One wr_req pulse, one done pulse, BSACK negated, busy = 0.
- DATI, addr 0x3FFFFC, len 2, slave returns inverted 0x1111, 0x2222, 0x3333:
  - Required: addresses 0x3FFFFC, 0x3FFFFE, 0x000000 (wrap).
  - Three rd_valid pulses with those values, in order.
  - BBS7 asserted for the first two cycles only.
- I/O-page DATO to 0x3FF400: BBS7g asserted with the address and negated after T_AH.
- No BRPLY during DATI len 3 word 0: error pulses 1000 cycles after BDIN. BSYNC, BDIN, BSACK and BDAL are released; no done pulse, no further rd_valid.
- Grant pass-through:
  - IDLE with BDMGIf low: BDMGOg = 1 combinationally.
  - In REQ, BDMGOg stays 0 and the block takes the grant.
- Reset asserted while BDOUTg is high: all gate drives, OE and Outbound go to 0 asynchronously; after release, the block is in IDLE with cmd_ready = 1.
